vga_sync_gen: RTL

//  640x480@60 VGA timing generator. Drives the pixel_x/pixel_y scan coordinates

---
 rtl/vga_sync_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator with a one-pixel registered, blanked output stage.
// Optional colour-bar generator is built in when VGA_TEST_PATTERN_EN is defined.
module vga_sync_gen #(
    parameter int DIV    = 4,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        p_tick,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [11:0] rgb_out
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [11:0]      rgb_q, rgb_d;

    logic             tick;
    logic             vis;
    logic             in_hs;
    logic             in_vs;
    logic [11:0]      pix_rgb;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    always_comb begin
        bar     = x_q[9:7];
        pix_rgb = test_mode ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : rgb_in;
    end
`else
    always_comb pix_rgb = rgb_in;
`endif

    always_comb begin
        tick  = (div_q == DIV_LAST);
        vis   = (x_q < H_VIS) && (y_q < V_VIS);
        in_hs = (x_q >= HS_START) && (x_q <= HS_END);
        in_vs = (y_q >= VS_START) && (y_q <= VS_END);

        div_d      = tick ? '0 : div_q + DIV_W'(1);
        x_d        = x_q;
        y_d        = y_q;
        video_on_d = video_on_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        rgb_d      = rgb_q;

        // Pipeline stage captures the pixel being left, so outputs trail the counters by one pixel.
        if (tick) begin
            video_on_d = vis;
            rgb_d      = vis ? pix_rgb : 12'h000;
            hsync_d    = ~in_hs;
            vsync_d    = ~in_vs;
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            video_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= 12'h000;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            video_on_q <= video_on_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            rgb_q      <= rgb_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign p_tick      = tick;
    assign frame_start = tick && (x_q == 10'd0) && (y_q == 10'd0);
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_out     = rgb_q;

endmodule
